// File: rtl/ncl_fa_serial_seq_if.sv
// Signal bundle between the clocked sequencer, its requester and the
// self-timed dual-rail full adder it drives.
interface ncl_fa_serial_seq_if #(parameter int W = 8);
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         err;
  logic [1:0]   fa_a;
  logic [1:0]   fa_b;
  logic [1:0]   fa_cin;
  logic         fa_ab_comp;
  logic         fa_cin_comp;
  logic [1:0]   fa_sum;
  logic [1:0]   fa_carry;
  logic         fa_sum_comp;
  logic         fa_carry_comp;

  modport slave (
    input  start, a_in, b_in, c_in,
    input  fa_ab_comp, fa_cin_comp, fa_sum, fa_carry,
    output busy, done, result, cout, err,
    output fa_a, fa_b, fa_cin, fa_sum_comp, fa_carry_comp
  );

  modport master (
    output start, a_in, b_in, c_in,
    output fa_ab_comp, fa_cin_comp, fa_sum, fa_carry,
    input  busy, done, result, cout, err,
    input  fa_a, fa_b, fa_cin, fa_sum_comp, fa_carry_comp
  );
endinterface

// File: rtl/ncl_fa_serial_seq.sv
// Bit-serial W-bit adder sequencer around one dual-rail NCL full adder:
// 4-phase DATA/NULL handshake per bit, LSB first, carry taken from the adder.
//
// state | meaning
// IDLE  | waiting for start
// DATA  | DATA wavefront on rails, waiting for DATA_OK
// CAPT  | capture sum/carry, raise receiver completion
// NULL  | NULL wavefront on rails, waiting for NULL_OK
// REL   | drop receiver completion, advance bit or finish
// DONE  | one-cycle done pulse
// ERR   | timeout or illegal code, held until init
module ncl_fa_serial_seq #(
  parameter int W       = 8,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               init,
  ncl_fa_serial_seq_if.slave bus
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_CAPT, S_NULL, S_REL, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic          carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0] fa_a_q, fa_a_d, fa_b_q, fa_b_d, fa_cin_q, fa_cin_d;
  logic       comp_q, comp_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  // Sample layout: {ab_comp, cin_comp, sum[1], sum[0], carry[1], carry[0]}
  logic [5:0] sync_q [SYNC];
  logic [5:0] prev_q;
  logic [5:0] smp;

  assign smp = sync_q[SYNC-1];

  function automatic logic is_data(input logic [5:0] v);
    return v[5] & v[4] & (v[3] ^ v[2]) & (v[1] ^ v[0]);
  endfunction

  function automatic logic is_illegal(input logic [5:0] v);
    return (&v[3:2]) | (&v[1:0]);
  endfunction

  logic data_ok, null_ok, illegal, in_op;

  // A condition only counts once two consecutive synchronized samples agree.
  assign data_ok = is_data(smp) & is_data(prev_q);
  assign null_ok = (smp == 6'b0) & (prev_q == 6'b0);
  assign illegal = is_illegal(smp);
  assign in_op   = (state_q == S_DATA) || (state_q == S_CAPT) ||
                   (state_q == S_NULL) || (state_q == S_REL);

  always_ff @(posedge clk) begin
    if (init) begin
      for (int k = 0; k < SYNC; k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {bus.fa_ab_comp, bus.fa_cin_comp, bus.fa_sum, bus.fa_carry};
      for (int k = 1; k < SYNC; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= smp;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      fa_a_q   <= 2'b00;
      fa_b_q   <= 2'b00;
      fa_cin_q <= 2'b00;
      comp_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      fa_a_q   <= fa_a_d;
      fa_b_q   <= fa_b_d;
      fa_cin_q <= fa_cin_d;
      comp_q   <= comp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_DATA;
      S_DATA: begin
        if (data_ok)            state_d = S_CAPT;
        else if (cnt_q == '0)   state_d = S_ERR;
      end
      S_CAPT: state_d = S_NULL;
      S_NULL: begin
        if (null_ok)            state_d = S_REL;
        else if (cnt_q == '0)   state_d = S_ERR;
      end
      S_REL:  state_d = (idx_q == LAST_IDX) ? S_DONE : S_DATA;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
    if (in_op && illegal) state_d = S_ERR;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE && bus.start) begin
      a_d     = bus.a_in;
      b_d     = bus.b_in;
      carry_d = bus.c_in;
      idx_d   = '0;
    end
    if (state_q == S_CAPT) begin
      res_d[idx_q] = smp[3];
      carry_d      = smp[1];
    end
    if (state_q == S_REL) begin
      if (idx_q == LAST_IDX) cout_d = carry_q;
      else                   idx_d  = idx_q + 1'b1;
    end
    if ((state_d == S_DATA || state_d == S_NULL) && state_d != state_q)
      cnt_d = CNT_LOAD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // Outputs are decoded from the next state so they are all plain flops.
  always_comb begin
    fa_a_d   = 2'b00;
    fa_b_d   = 2'b00;
    fa_cin_d = 2'b00;
    comp_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_d)
      S_DATA, S_CAPT: begin
        fa_a_d   = {a_d[idx_d], ~a_d[idx_d]};
        fa_b_d   = {b_d[idx_d], ~b_d[idx_d]};
        fa_cin_d = {carry_d, ~carry_d};
        comp_d   = (state_d == S_CAPT);
        busy_d   = 1'b1;
      end
      S_NULL: begin
        comp_d = 1'b1;
        busy_d = 1'b1;
      end
      S_REL:  busy_d = 1'b1;
      S_DONE: done_d = 1'b1;
      S_ERR:  err_d  = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.result        = res_q;
  assign bus.cout          = cout_q;
  assign bus.err           = err_q;
  assign bus.fa_a          = fa_a_q;
  assign bus.fa_b          = fa_b_q;
  assign bus.fa_cin        = fa_cin_q;
  assign bus.fa_sum_comp   = comp_q;
  assign bus.fa_carry_comp = comp_q;
endmodule

// File: tb/tb_ncl_fa_serial_seq.sv
// Bench for ncl_fa_serial_seq: behavioural dual-rail adder with random
// per-output delays, arithmetic reference, error and abort scenarios.
module tb_ncl_fa_serial_seq;
  localparam int W        = 4;
  localparam int SYNC     = 2;
  localparam int TO_MAIN  = 255;
  localparam int TO_SHORT = 8;

  logic clk = 1'b0;
  logic init;
  always #5 clk = ~clk;

  ncl_fa_serial_seq_if #(.W(W)) ifc ();
  ncl_fa_serial_seq_if #(.W(W)) ifs ();

  ncl_fa_serial_seq #(.W(W), .SYNC(SYNC), .TIMEOUT(TO_MAIN)) u_dut (
    .clk (clk), .init(init), .bus(ifc)
  );
  ncl_fa_serial_seq #(.W(W), .SYNC(SYNC), .TIMEOUT(TO_SHORT)) u_dut_to (
    .clk (clk), .init(init), .bus(ifs)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Adder model: groups 0=ab ack, 1=cin ack, 2=sum, 3=carry, each with its own delay.
  logic [1:0] cur [4];
  logic [1:0] tgt [4];
  logic [1:0] nt  [4];
  int         pend [4];
  int         maxd = 0;
  bit         force11 = 1'b0;
  int         data_waves = 0;
  int         viol_hold = 0;
  int         viol_4ph = 0;
  logic [1:0] pa = 2'b00, pb = 2'b00, pc = 2'b00;
  logic       rd, rn, s_bit, c_bit;

  function automatic logic is_dr(input logic [1:0] v);
    return (v == 2'b01) || (v == 2'b10);
  endfunction

  always @(negedge clk) begin
    if (pa != 2'b00 && ifc.fa_a != 2'b00 &&
        (ifc.fa_a != pa || ifc.fa_b != pb || ifc.fa_cin != pc))
      viol_hold++;
    if (pa == 2'b00 && ifc.fa_a != 2'b00) begin
      data_waves++;
      if (cur[0] != 0 || cur[1] != 0 || cur[2] != 0 || cur[3] != 0) viol_4ph++;
    end
    pa = ifc.fa_a;
    pb = ifc.fa_b;
    pc = ifc.fa_cin;
    if (init === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        cur[k] = 2'b00; tgt[k] = 2'b00; pend[k] = 0;
      end
    end else begin
      rd = is_dr(ifc.fa_a) && is_dr(ifc.fa_b) && is_dr(ifc.fa_cin);
      rn = (ifc.fa_a == 0) && (ifc.fa_b == 0) && (ifc.fa_cin == 0);
      for (int k = 0; k < 4; k++) nt[k] = tgt[k];
      if (rd && !ifc.fa_sum_comp && !ifc.fa_carry_comp) begin
        s_bit = ifc.fa_a[1] ^ ifc.fa_b[1] ^ ifc.fa_cin[1];
        c_bit = (ifc.fa_a[1] & ifc.fa_b[1]) | (ifc.fa_a[1] & ifc.fa_cin[1]) |
                (ifc.fa_b[1] & ifc.fa_cin[1]);
        nt[0] = 2'b01; nt[1] = 2'b01;
        nt[2] = {s_bit, ~s_bit};
        nt[3] = {c_bit, ~c_bit};
      end else if (rn && ifc.fa_sum_comp && ifc.fa_carry_comp) begin
        for (int k = 0; k < 4; k++) nt[k] = 2'b00;
      end
      for (int k = 0; k < 4; k++) begin
        if (nt[k] != tgt[k]) begin
          tgt[k]  = nt[k];
          pend[k] = int'($urandom_range(maxd, 0));
        end
        if (cur[k] != tgt[k]) begin
          if (pend[k] == 0) cur[k] = tgt[k];
          else pend[k]--;
        end
      end
    end
    ifc.fa_ab_comp  = cur[0][0];
    ifc.fa_cin_comp = cur[1][0];
    ifc.fa_sum      = force11 ? 2'b11 : cur[2];
    ifc.fa_carry    = cur[3];
  end

  task automatic chk_reset();
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_err", ifc.err, 0);
    chk("rst_result", ifc.result, 0);
    chk("rst_cout", ifc.cout, 0);
    chk("rst_rails", {ifc.fa_a, ifc.fa_b, ifc.fa_cin}, 0);
    chk("rst_comps", {ifc.fa_sum_comp, ifc.fa_carry_comp}, 0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input int poke, output int lat);
    logic [W:0] exp;
    int w0, extra;
    exp = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
    @(negedge clk);
    ifc.a_in = a; ifc.b_in = b; ifc.c_in = ci; ifc.start = 1'b1;
    w0 = data_waves;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("busy_after_start", ifc.busy, 1);
    lat = 1;
    while (!ifc.done && lat < 2000) begin
      if (poke != 0 && lat == poke) begin
        ifc.a_in = ~a; ifc.b_in = ~b; ifc.c_in = ~ci; ifc.start = 1'b1;
      end else ifc.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    ifc.start = 1'b0;
    chk("done_seen", ifc.done, 1);
    chk("result", ifc.result, exp[W-1:0]);
    chk("cout", ifc.cout, exp[W]);
    chk("data_waves", data_waves - w0, W);
    @(negedge clk);
    chk("done_one_cycle", {ifc.done, ifc.busy}, 0);
    if (poke != 0) begin
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if (ifc.done || ifc.busy) extra++;
      end
      chk("start_not_queued", extra, 0);
    end
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, w0, dcount;
    logic [W-1:0] ra, rb;
    init = 1'b1;
    ifc.start = 1'b0; ifc.a_in = '0; ifc.b_in = '0; ifc.c_in = 1'b0;
    ifs.start = 1'b0; ifs.a_in = '0; ifs.b_in = '0; ifs.c_in = 1'b0;
    ifs.fa_ab_comp = 1'b0; ifs.fa_cin_comp = 1'b1;
    ifs.fa_sum = 2'b01; ifs.fa_carry = 2'b10;
    repeat (3) @(negedge clk);
    chk_reset();
    init = 1'b0;
    @(negedge clk);

    // directed, zero-delay adder
    run_op(4'b0101, 4'b0011, 1'b0, 0, lat);
    chk("latency_min", lat >= W * 10, 1);
    run_op(4'b1111, 4'b0001, 1'b0, 0, lat);
    run_op(4'b0000, 4'b0000, 1'b1, 0, lat);

    // abort in NULL phase of bit 1
    @(negedge clk);
    ifc.a_in = 4'b0110; ifc.b_in = 4'b0111; ifc.c_in = 1'b1; ifc.start = 1'b1;
    w0 = data_waves;
    @(negedge clk);
    ifc.start = 1'b0;
    n = 0;
    while ((data_waves - w0 < 2 || ifc.fa_a != 2'b00) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("reach_bit1_null", (data_waves - w0 == 2) && (ifc.fa_a == 2'b00), 1);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk_reset();
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifc.done || ifc.busy) dcount++;
    end
    chk("no_done_after_abort", dcount, 0);
    run_op(4'b1001, 4'b0110, 1'b1, 0, lat);
    run_op(4'b1010, 4'b0111, 1'b0, 15, lat);

    // illegal sum code during bit 2
    @(negedge clk);
    ifc.a_in = 4'b1100; ifc.b_in = 4'b0101; ifc.c_in = 1'b0; ifc.start = 1'b1;
    w0 = data_waves;
    @(negedge clk);
    ifc.start = 1'b0;
    n = 0;
    while (data_waves - w0 < 3 && n < 200) begin @(negedge clk); n++; end
    chk("reach_bit2_data", data_waves - w0, 3);
    force11 = 1'b1;
    n = 0; dcount = 0;
    while (!ifc.err && n < 50) begin
      @(negedge clk); n++;
      if (ifc.done) dcount++;
    end
    chk("illegal_err", ifc.err, 1);
    chk("illegal_rails", {ifc.fa_a, ifc.fa_b, ifc.fa_cin}, 0);
    chk("illegal_busy", ifc.busy, 0);
    chk("illegal_no_done", dcount, 0);
    force11 = 1'b0;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_ignores_start", {ifc.busy, ifc.err, ifc.fa_a}, {1'b0, 1'b1, 2'b00});
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk_reset();
    run_op(4'b0011, 4'b0011, 1'b1, 0, lat);

    // random operands, random adder delays and skew
    maxd = 6;
    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, 1'($urandom), 0, lat);
    end
    chk("rail_hold_viol", viol_hold, 0);
    chk("four_phase_viol", viol_4ph, 0);

    // stuck A/B ack on the short-timeout instance
    @(negedge clk);
    ifs.a_in = 4'b0101; ifs.b_in = 4'b1010; ifs.start = 1'b1;
    @(negedge clk);
    ifs.start = 1'b0;
    lat = 1; dcount = 0;
    while (!ifs.err && lat < 100) begin
      @(negedge clk); lat++;
      if (ifs.done) dcount++;
    end
    chk("timeout_err", ifs.err, 1);
    chk("timeout_not_early", lat >= TO_SHORT, 1);
    chk("timeout_bound", lat <= TO_SHORT + SYNC + 2, 1);
    chk("timeout_no_done", dcount, 0);
    chk("timeout_idle_outs", {ifs.busy, ifs.fa_a, ifs.fa_b, ifs.fa_cin}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
